uart_tx_sched: RTL

- Round-robin scheduler that shares one UART serial transmitter (the PISO framer) among N_REQ byte requesters.
- Arbitrates among requesters, latches the winner's byte and computes its parity.
- Issues a one-cycle load strobe to the transmitter, then tracks the transmitter's busy flag until the frame has left.
- Enforces a configurable inter-frame idle gap. Sits between the host-side byte sources and the transmitter.

---
 rtl/uart_tx_sched_if.sv | 23 ++
 rtl/uart_tx_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester and transmitter handshake bundle for uart_tx_sched
interface uart_tx_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   o_ack;
  logic               o_data_valid;
  logic               o_par_en;
  logic               o_par_bit;
  logic [7:0]         o_p_data;
  logic               i_busy;

  modport master (
    input  i_req, i_req_data, i_busy,
    output o_ack, o_data_valid, o_par_en, o_par_bit, o_p_data
  );

  modport slave (
    output i_req, i_req_data, i_busy,
    input  o_ack, o_data_valid, o_par_en, o_par_bit, o_p_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter among N_REQ requesters
module uart_tx_sched #(
  parameter int N_REQ         = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 4,
  parameter int IDW           = $clog2(N_REQ)
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  uart_tx_sched_if.master bus,
  input  logic            i_par_en,
  input  logic            i_par_odd,
  output logic [IDW-1:0]  o_grant_id,
  output logic            o_active,
  output logic            o_err,
  output logic [15:0]     o_frame_cnt
);
  localparam int TW = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_START, S_WAIT_DONE, S_GAP
  } state_t;

  state_t          r_state, w_next;
  logic [IDW-1:0]  r_ptr, w_win, w_idx;
  logic            w_any;
  logic [7:0]      w_byte;
  logic            w_par;
  logic [TW-1:0]   r_tcnt;
  logic [3:0]      r_gcnt;
  logic [15:0]     r_frame_cnt;
  logic            w_timeout, w_done, w_gap_end;

  // Scan from the slot after the last winner so the previous winner is checked last.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = (r_ptr >= IDW'(N_REQ - i)) ? r_ptr - IDW'(N_REQ - i) : r_ptr + IDW'(i);
      if (!w_any && bus.i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == IDW'(k)) w_byte = bus.i_req_data[8*k +: 8];
    end
  end

  assign w_par     = i_par_en & (^w_byte ^ i_par_odd);
  assign w_timeout = (r_state == S_WAIT_START) && !bus.i_busy && (r_tcnt == TW'(START_TIMEOUT - 1));
  assign w_done    = (r_state == S_WAIT_DONE) && !bus.i_busy;
  assign w_gap_end = (GAP_CYCLES == 0) || (r_gcnt == 4'(GAP_CYCLES - 1));
  assign o_frame_cnt = r_frame_cnt;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_any) w_next = S_LOAD;
      S_LOAD:       w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (bus.i_busy)     w_next = S_WAIT_DONE;
        else if (w_timeout) w_next = S_GAP;
      end
      S_WAIT_DONE:  if (w_done) w_next = S_GAP;
      S_GAP:        if (w_gap_end) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Ack is combinational in IDLE so the strobe lands exactly one cycle after it.
  always_comb begin
    bus.o_ack        = '0;
    bus.o_data_valid = 1'b0;
    o_active         = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any && i_arst_n) bus.o_ack = N_REQ'(1) << w_win;
      S_LOAD:  begin
        bus.o_data_valid = !bus.i_busy;
        o_active         = 1'b1;
      end
      default: o_active = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ptr         <= IDW'(N_REQ - 1);
      o_grant_id    <= '0;
      bus.o_p_data  <= 8'h00;
      bus.o_par_en  <= 1'b0;
      bus.o_par_bit <= 1'b0;
      r_tcnt        <= '0;
      r_gcnt        <= 4'd0;
      o_err         <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_ptr         <= w_win;
        o_grant_id    <= w_win;
        bus.o_p_data  <= w_byte;
        bus.o_par_en  <= i_par_en;
        bus.o_par_bit <= w_par;
      end
      r_tcnt <= (r_state == S_WAIT_START) ? r_tcnt + 1'b1 : '0;
      r_gcnt <= (r_state == S_GAP) ? r_gcnt + 4'd1 : 4'd0;
      if (w_timeout) o_err <= 1'b1;
      if (w_done)    r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
endmodule
